// File: rtl/lime_mem_defs.sv
// Shared definitions for the unified instruction/data memory path.
// Contents:
//   state_e                  transaction sequencer states (3-bit)
//   OWNER_CPU / OWNER_LDR    requester indices used for grants and owner
//   DEF_ADDR_W / DEF_DATA_W  default memory address and data widths
package lime_mem_defs;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CAPT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_LDR = 1'b1;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

endpackage

// File: rtl/rr_arb2.sv
// Two-way combinational arbiter for shared resources.
// Ports:
//   req0_i       request from requester 0
//   req1_i       request from requester 1
//   last_i       index of the requester served most recently
//   fixed_pri_i  1 = requester 0 always wins a tie; 0 = round-robin on ties
//   gnt_o        index of the winning requester (0 when nothing is requested)
//   valid_o      at least one request is present
module rr_arb2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  input  logic fixed_pri_i,
  output logic gnt_o,
  output logic valid_o
);

  // A lone request always wins; on a tie the requester that did not go last
  // wins, unless fixed priority pins the grant to requester 0.
  assign gnt_o   = (req0_i && req1_i) ? (fixed_pri_i ? 1'b0 : ~last_i) : req1_i;
  assign valid_o = req0_i | req1_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the unified memory between the processor core and the loader/debug
// port, running each access as a fixed-latency transaction:
// IDLE -> ISSUE -> WAIT -> CAPT -> DONE -> IDLE.
// Ports:
//   CLK, Reset                      clock (rising edge), async active-high reset
//   cpu_req/we/addr/wdata           core request; req held until cpu_ack
//   cpu_ack, cpu_rdata              core completion pulse and held read data
//   ldr_req/we/addr/wdata           loader request; req held until ldr_ack
//   ldr_ack, ldr_rdata              loader completion pulse and held read data
//   mem_en/we/addr/wdata            one-cycle memory strobe and its fields
//   mem_rdata                       memory read data, valid MEM_LAT cycles after mem_en
//   busy                            high in every state except IDLE
//   owner                           current or last grant (0 = core, 1 = loader)
module mem_port_arbiter
  import lime_mem_defs::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MEM_LAT   = 2,   // legal range 1..15
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_ack,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                owner_q;
  logic                last_q;
  logic                cpu_ack_q, ldr_ack_q;
  logic [DATA_W-1:0]   cpu_rdata_q, ldr_rdata_q;
  logic                gnt_idx, gnt_vld;

  rr_arb2 u_arb (
    .req0_i      (cpu_req),
    .req1_i      (ldr_req),
    .last_i      (last_q),
    .fixed_pri_i (FIXED_PRI),
    .gnt_o       (gnt_idx),
    .valid_o     (gnt_vld)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from the same pre-edge values, whatever the process order.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. Requests only matter in IDLE.
  // NOTE: the default assignment up front gives every path a value, so no
  // latch is inferred for state_d.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (gnt_vld) state_d = ST_ISSUE;
      ST_ISSUE: state_d = (MEM_LAT > 1) ? ST_WAIT : ST_CAPT;
      // cnt_q == 1 means this decrement brings the count to zero.
      ST_WAIT:  if (cnt_q == 4'd1) state_d = ST_CAPT;
      ST_CAPT:  state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state only: no combinational path from the requests.
  always_comb begin
    mem_en = 1'b0;
    busy   = 1'b1;
    case (state_q)
      ST_IDLE:  busy   = 1'b0;
      ST_ISSUE: mem_en = 1'b1;
      default:  ;
    endcase
    mem_we = mem_en & we_q;
  end

  // Latched request fields, latency counter, read-data capture and acks.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      owner_q     <= OWNER_CPU;
      last_q      <= OWNER_LDR;   // core wins the first tie
      cpu_ack_q   <= 1'b0;
      ldr_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      cpu_ack_q <= 1'b0;
      ldr_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (gnt_vld) begin
            owner_q <= gnt_idx;
            if (gnt_idx == OWNER_LDR) begin
              we_q    <= ldr_we;
              addr_q  <= ldr_addr;
              wdata_q <= ldr_wdata;
            end else begin
              we_q    <= cpu_we;
              addr_q  <= cpu_addr;
              wdata_q <= cpu_wdata;
            end
          end
        end
        ST_ISSUE: cnt_q <= LAT_M1;
        ST_WAIT:  cnt_q <= cnt_q - 4'd1;
        ST_CAPT: begin
          if (!we_q) begin
            if (owner_q == OWNER_CPU) cpu_rdata_q <= mem_rdata;
            else                      ldr_rdata_q <= mem_rdata;
          end
        end
        ST_DONE: begin
          last_q <= owner_q;
          if (owner_q == OWNER_CPU) cpu_ack_q <= 1'b1;
          else                      ldr_ack_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign ldr_ack   = ldr_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ldr_rdata = ldr_rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Four instances cover the
// parameter points: [0] MEM_LAT=2 round-robin, [1] MEM_LAT=2 fixed priority,
// [2] MEM_LAT=4, [3] MEM_LAT=1. Requests reach only the instance named by sel.
module tb_mem_port_arbiter;

  logic        CLK;
  logic        Reset;
  int          sel;
  logic        cpu_req, cpu_we, ldr_req, ldr_we;
  logic [15:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;

  logic        cpu_ack_w [4];
  logic        ldr_ack_w [4];
  logic        mem_en_w  [4];
  logic        mem_we_w  [4];
  logic        busy_w    [4];
  logic        owner_w   [4];
  logic [15:0] cpu_rdata_w [4];
  logic [15:0] ldr_rdata_w [4];
  logic [15:0] mem_addr_w  [4];
  logic [15:0] mem_wdata_w [4];
  logic [15:0] mem_rdata_w [4];

  int n_cmp = 0;
  int n_bad = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [15:0] dflt(input logic [11:0] a);
    case (a)
      12'h010: return 16'hBEEF;
      12'h020: return 16'h2222;
      12'h030: return 16'h3333;
      default: return {4'h5, a};
    endcase
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int LAT = (g == 2) ? 4 : (g == 3) ? 1 : 2;
    localparam bit PRI = (g == 1);
    logic cpu_req_g, ldr_req_g;
    bit [15:0] mem_q [4096];
    bit        wr_q  [4096];
    logic [15:0] pend;
    int cnt = 0;

    assign cpu_req_g = cpu_req & (sel == g);
    assign ldr_req_g = ldr_req & (sel == g);

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT), .FIXED_PRI(PRI)) u_dut (
      .CLK(CLK), .Reset(Reset),
      .cpu_req(cpu_req_g), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack_w[g]), .cpu_rdata(cpu_rdata_w[g]),
      .ldr_req(ldr_req_g), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
      .ldr_ack(ldr_ack_w[g]), .ldr_rdata(ldr_rdata_w[g]),
      .mem_en(mem_en_w[g]), .mem_we(mem_we_w[g]), .mem_addr(mem_addr_w[g]),
      .mem_wdata(mem_wdata_w[g]), .mem_rdata(mem_rdata_w[g]),
      .busy(busy_w[g]), .owner(owner_w[g])
    );

    // Memory model: data is presented only in the cycle exactly LAT cycles
    // after the strobe; any other cycle shows a poison value.
    always @(posedge CLK) begin
      if (mem_en_w[g]) begin
        pend <= wr_q[mem_addr_w[g][11:0]] ? mem_q[mem_addr_w[g][11:0]] : dflt(mem_addr_w[g][11:0]);
        if (mem_we_w[g]) begin
          mem_q[mem_addr_w[g][11:0]] <= mem_wdata_w[g];
          wr_q[mem_addr_w[g][11:0]]  <= 1'b1;
        end
        cnt <= LAT;
      end else if (cnt > 0) begin
        cnt <= cnt - 1;
      end
    end
    assign mem_rdata_w[g] = (cnt == 1) ? pend : 16'hDEAD;
  end

  typedef struct {
    int          idx;
    bit          port;   // 0 = core, 1 = loader
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;  // expected read data (reads only)
    int          lat;    // expected cycles from request to ack
    string       tag;
  } vec_t;

  function automatic vec_t mk(input int idx, input bit port, input bit we,
                              input logic [15:0] addr, input logic [15:0] wdata,
                              input logic [15:0] rdata, input int lat, input string tag);
    vec_t v;
    v.idx = idx; v.port = port; v.we = we; v.addr = addr;
    v.wdata = wdata; v.rdata = rdata; v.lat = lat; v.tag = tag;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_reset();
    @(posedge CLK); #1;
    cpu_req = 1'b0; ldr_req = 1'b0;
    Reset = 1'b1;
    repeat (2) @(posedge CLK);
    #1 Reset = 1'b0;
  endtask

  // One isolated transaction; the request is dropped as soon as ack is seen.
  task automatic run_txn(input vec_t v);
    int k, ack_k, en_k, en_cnt, other_ack, busy_low;
    logic [15:0] en_addr, en_wdata, own_before, other_before, own_after, other_after;
    logic en_we, en_owner, busy_at_ack;
    own_before   = v.port ? ldr_rdata_w[v.idx] : cpu_rdata_w[v.idx];
    other_before = v.port ? cpu_rdata_w[v.idx] : ldr_rdata_w[v.idx];
    sel = v.idx;
    @(posedge CLK); #1;
    if (v.port) begin
      ldr_we = v.we; ldr_addr = v.addr; ldr_wdata = v.wdata; ldr_req = 1'b1;
    end else begin
      cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata; cpu_req = 1'b1;
    end
    k = 0; ack_k = -1; en_k = -1; en_cnt = 0; other_ack = 0; busy_low = 0;
    en_addr = '0; en_wdata = '0; en_we = 1'b0; en_owner = 1'b0; busy_at_ack = 1'b1;
    while (ack_k < 0 && k < 40) begin
      @(posedge CLK); #1; k++;
      if (mem_en_w[v.idx]) begin
        en_cnt++;
        if (en_k < 0) begin
          en_k = k; en_addr = mem_addr_w[v.idx]; en_wdata = mem_wdata_w[v.idx];
          en_we = mem_we_w[v.idx]; en_owner = owner_w[v.idx];
        end
      end
      if (v.port ? cpu_ack_w[v.idx] : ldr_ack_w[v.idx]) other_ack++;
      if (v.port ? ldr_ack_w[v.idx] : cpu_ack_w[v.idx]) begin
        ack_k = k; busy_at_ack = busy_w[v.idx];
        cpu_req = 1'b0; ldr_req = 1'b0;
      end else if (!busy_w[v.idx]) begin
        busy_low++;
      end
    end
    cpu_req = 1'b0; ldr_req = 1'b0;
    own_after   = v.port ? ldr_rdata_w[v.idx] : cpu_rdata_w[v.idx];
    other_after = v.port ? cpu_rdata_w[v.idx] : ldr_rdata_w[v.idx];
    check({v.tag, " ack_latency"}, ack_k, v.lat);
    check({v.tag, " mem_en_count"}, en_cnt, 1);
    check({v.tag, " mem_en_cycle"}, en_k, 1);
    check({v.tag, " mem_addr"}, en_addr, v.addr);
    check({v.tag, " mem_we"}, en_we, v.we);
    if (v.we) check({v.tag, " mem_wdata"}, en_wdata, v.wdata);
    check({v.tag, " owner"}, en_owner, v.port);
    check({v.tag, " busy_low_mid_txn"}, busy_low, 0);
    check({v.tag, " busy_at_ack"}, busy_at_ack, 1'b0);
    check({v.tag, " other_ack"}, other_ack, 0);
    check({v.tag, " own_rdata"}, own_after, v.we ? own_before : v.rdata);
    check({v.tag, " other_rdata"}, other_after, other_before);
  endtask

  // Both requesters held together; exp_seq bit i is the port of ack i.
  task automatic run_pair(input int idx, input int n_total, input int drop_cpu_at,
                          input logic [3:0] exp_seq, input string tag);
    int k, n, m, dbl;
    int ack_cyc [4];
    logic [3:0] ack_seq, own_seq;
    sel = idx;
    @(posedge CLK); #1;
    cpu_we = 1'b0; cpu_addr = 16'h0010; ldr_we = 1'b0; ldr_addr = 16'h0030;
    cpu_req = 1'b1; ldr_req = 1'b1;
    k = 0; n = 0; m = 0; dbl = 0; ack_seq = '0; own_seq = '0;
    for (int i = 0; i < 4; i++) ack_cyc[i] = 0;
    while (n < n_total && k < 80) begin
      @(posedge CLK); #1; k++;
      if (mem_en_w[idx] && m < 4) begin own_seq[m] = owner_w[idx]; m++; end
      if (cpu_ack_w[idx] && ldr_ack_w[idx]) dbl++;
      if (cpu_ack_w[idx] || ldr_ack_w[idx]) begin
        ack_seq[n] = ldr_ack_w[idx]; ack_cyc[n] = k; n++;
        if (n == drop_cpu_at) cpu_req = 1'b0;
        if (n == n_total) begin cpu_req = 1'b0; ldr_req = 1'b0; end
      end
    end
    cpu_req = 1'b0; ldr_req = 1'b0;
    check({tag, " ack_count"}, n, n_total);
    check({tag, " grant_count"}, m, n_total);
    check({tag, " ack_order"}, ack_seq, exp_seq);
    check({tag, " owner_order"}, own_seq, exp_seq);
    check({tag, " double_ack"}, dbl, 0);
    for (int i = 0; i < n_total; i++)
      check($sformatf("%s ack%0d_cycle", tag, i), ack_cyc[i], 5 * (i + 1));
    check({tag, " cpu_rdata"}, cpu_rdata_w[idx], 16'hBEEF);
    check({tag, " ldr_rdata"}, ldr_rdata_w[idx], 16'h3333);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  vec_t vecs [9];

  initial begin
    int k, n, m, acks, ens;
    logic [15:0] en_addr [2];
    int en_cyc [2];
    int ack_cyc [2];
    logic [15:0] rd [2];

    Reset = 1'b1; sel = 0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;
    repeat (3) @(posedge CLK);
    #1;
    for (int g = 0; g < 4; g++) begin
      check($sformatf("reset[%0d] busy", g), busy_w[g], 1'b0);
      check($sformatf("reset[%0d] mem_en", g), mem_en_w[g], 1'b0);
      check($sformatf("reset[%0d] mem_we", g), mem_we_w[g], 1'b0);
      check($sformatf("reset[%0d] mem_addr", g), mem_addr_w[g], 16'h0000);
      check($sformatf("reset[%0d] cpu_ack", g), cpu_ack_w[g], 1'b0);
      check($sformatf("reset[%0d] ldr_ack", g), ldr_ack_w[g], 1'b0);
      check($sformatf("reset[%0d] owner", g), owner_w[g], 1'b0);
      check($sformatf("reset[%0d] cpu_rdata", g), cpu_rdata_w[g], 16'h0000);
      check($sformatf("reset[%0d] ldr_rdata", g), ldr_rdata_w[g], 16'h0000);
    end
    Reset = 1'b0;

    vecs[0] = mk(0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 5, "t1_cpu_rd");
    vecs[1] = mk(0, 1'b1, 1'b1, 16'h0100, 16'h1234, 16'h0000, 5, "t4_ldr_wr");
    vecs[2] = mk(0, 1'b0, 1'b0, 16'h0100, 16'h0000, 16'h1234, 5, "t4_cpu_rd");
    vecs[3] = mk(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 5, "ldr_rd");
    vecs[4] = mk(0, 1'b0, 1'b1, 16'h0040, 16'hA5C3, 16'h0000, 5, "cpu_wr");
    vecs[5] = mk(0, 1'b1, 1'b0, 16'h0040, 16'h0000, 16'hA5C3, 5, "ldr_rd_back");
    vecs[6] = mk(3, 1'b0, 1'b0, 16'h0030, 16'h0000, 16'h3333, 4, "lat1_cpu_rd");
    vecs[7] = mk(2, 1'b1, 1'b1, 16'h0050, 16'h0F0F, 16'h0000, 7, "lat4_ldr_wr");
    vecs[8] = mk(2, 1'b0, 1'b0, 16'h0050, 16'h0000, 16'h0F0F, 7, "lat4_cpu_rd");
    for (int i = 0; i < 9; i++) run_txn(vecs[i]);

    // Round-robin tie: core first, then strict alternation while both hold.
    pulse_reset();
    run_pair(0, 4, 99, 4'b1010, "rr_tie");

    // Fixed priority: core served until it drops, then the loader.
    pulse_reset();
    run_pair(1, 4, 3, 4'b1000, "fixed_pri");

    // Address change after grant is ignored; held req starts a second access.
    sel = 0;
    @(posedge CLK); #1;
    cpu_we = 1'b0; cpu_addr = 16'h0020; cpu_req = 1'b1;
    k = 0; n = 0; m = 0;
    en_addr[0] = '0; en_addr[1] = '0; en_cyc[0] = 0; en_cyc[1] = 0;
    ack_cyc[0] = 0; ack_cyc[1] = 0; rd[0] = '0; rd[1] = '0;
    while (n < 2 && k < 40) begin
      @(posedge CLK); #1; k++;
      if (k == 1) cpu_addr = 16'h0030;
      if (mem_en_w[0] && m < 2) begin en_addr[m] = mem_addr_w[0]; en_cyc[m] = k; m++; end
      if (cpu_ack_w[0]) begin
        rd[n] = cpu_rdata_w[0]; ack_cyc[n] = k; n++;
        if (n == 2) cpu_req = 1'b0;
      end
    end
    cpu_req = 1'b0;
    check("t5 ack_count", n, 2);
    check("t5 grant_count", m, 2);
    check("t5 first mem_addr", en_addr[0], 16'h0020);
    check("t5 first mem_en_cycle", en_cyc[0], 1);
    check("t5 first rdata", rd[0], 16'h2222);
    check("t5 first ack_cycle", ack_cyc[0], 5);
    check("t5 second mem_addr", en_addr[1], 16'h0030);
    check("t5 second mem_en_cycle", en_cyc[1], 6);
    check("t5 second rdata", rd[1], 16'h3333);
    check("t5 second ack_cycle", ack_cyc[1], 10);

    // Reset in the middle of a MEM_LAT=4 WAIT: transaction discarded.
    pulse_reset();
    sel = 2;
    @(posedge CLK); #1;
    cpu_we = 1'b0; cpu_addr = 16'h0010; cpu_req = 1'b1;
    repeat (3) begin @(posedge CLK); #1; end
    check("t6 busy_before_reset", busy_w[2], 1'b1);
    Reset = 1'b1;
    #1;
    check("t6 busy_in_reset", busy_w[2], 1'b0);
    check("t6 mem_en_in_reset", mem_en_w[2], 1'b0);
    check("t6 cpu_ack_in_reset", cpu_ack_w[2], 1'b0);
    check("t6 ldr_ack_in_reset", ldr_ack_w[2], 1'b0);
    cpu_req = 1'b0;
    repeat (2) @(posedge CLK);
    #1 Reset = 1'b0;
    acks = 0; ens = 0;
    repeat (12) begin
      @(posedge CLK); #1;
      if (cpu_ack_w[2] || ldr_ack_w[2]) acks++;
      if (mem_en_w[2]) ens++;
    end
    check("t6 no_ack_after_reset", acks, 0);
    check("t6 no_mem_en_after_reset", ens, 0);
    run_txn(mk(2, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 7, "t6_reissue"));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified 16-bit instruction/data memory between two requesters:
  - the processor core, i.e. the multi-cycle control FSM's MemR/MemW/IoD-qualified accesses;
  - the program loader/debug port.
- Sequences each access as a fixed-latency transaction: arbitrate, issue, wait, acknowledge.
- Reports busy to the core so the control FSM can hold its current state while an access is pending.

Parameters:
ADDR_W, 16, memory address width
DATA_W, 16, memory data width
MEM_LAT, 2, memory read/write latency in cycles, legal range 1..15
FIXED_PRI, 0, 0 = round-robin on ties; 1 = core always wins ties

Ports:
CLK  input  1  clock, rising edge
Reset  input  1  asynchronous, active-high reset
cpu_req  input  1  core access request; held until cpu_ack
cpu_we  input  1  1 = write, 0 = read
cpu_addr  input  ADDR_W  core address
cpu_wdata  input  DATA_W  core write data
cpu_ack  output  1  one-cycle completion pulse
cpu_rdata  output  DATA_W  read data; valid with cpu_ack, held until the next core ack
ldr_req  input  1  loader request; held until ldr_ack
ldr_we  input  1  loader write enable
ldr_addr  input  ADDR_W  loader address
ldr_wdata  input  DATA_W  loader write data
ldr_ack  output  1  one-cycle completion pulse
ldr_rdata  output  DATA_W  read data; valid with ldr_ack, held until the next loader ack
mem_en  output  1  one-cycle memory strobe
mem_we  output  1  memory write enable, qualified by mem_en
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle
busy  output  1  high in every state except IDLE
owner  output  1  current or last grant: 0 = core, 1 = loader

Behaviour:
- Reset values: state IDLE; all outputs 0; internal last-owner register = loader (1), so the core wins the first tie.
- State machine: IDLE -> ISSUE -> WAIT -> CAPT -> DONE -> IDLE.
- IDLE:
  - If any req is high, pick a winner, latch its we/addr/wdata into registers, set owner, go to ISSUE.
  - Otherwise stay in IDLE.
- Tie rule: FIXED_PRI=0 grants the requester that is not last-owner. FIXED_PRI=1 always grants the core.
- Single request: granted regardless of last-owner.
- ISSUE:
  - mem_en=1 for exactly this cycle; mem_we/addr/wdata come from the latched registers.
  - Load counter with MEM_LAT-1. Go to WAIT if MEM_LAT>1, else go to CAPT.
- WAIT: decrement counter each cycle; go to CAPT when the counter reaches 0.
- CAPT:
  - This cycle is exactly MEM_LAT cycles after ISSUE.
  - On a read, register mem_rdata into the winner's rdata register at the end of the cycle.
  - On a write, no capture. Go to DONE.
- DONE:
  - Pulse the winner's ack for one cycle. Update last-owner to the winner. Go to IDLE.
- Latency: req high in IDLE cycle N -> mem_en in N+1 -> ack in N+MEM_LAT+3. Reads and writes take the same latency.
- Requester rules:
  - req must be held until ack, and must be dropped or re-presented in the cycle after ack.
  - A req still high in the IDLE cycle after DONE is a new transaction, so back-to-back accesses are legal.
- Request inputs are ignored outside IDLE. Changes to addr/wdata/we after grant have no effect.
- The loser's request stays pending and is served in the next IDLE. Under round-robin, neither requester waits more than one foreign transaction.
- mem_en, mem_we, ack and busy are driven from registers or from decoded state only, with no combinational path from req inputs.
- rdata for the non-winning port is never modified.
- Reset mid-transaction: immediate return to IDLE; mem_en and both acks drop; the transaction is discarded with no ack; the requester re-issues.
  - A write that already saw mem_en may have landed in memory; that is acceptable.

Decomposition:
- Shared package/include `lime_mem_defs`: state encodings (IDLE=0, ISSUE=1, WAIT=2, CAPT=3, DONE=4, 3-bit), OWNER_CPU=0, OWNER_LDR=1, default ADDR_W/DATA_W.
- Sub-module `rr_arb2`: purely combinational 2-way pick from (req0, req1, last, fixed_pri), producing grant index and valid. Reused by future two-port shared resources.
- The top module holds the FSM, latency counter, latched request fields and rdata registers.

Test Plan:
1. Reset, then core read addr 0x0010 with memory model returning 0xBEEF, MEM_LAT=2 -> mem_en high one cycle 1 cycle after req with mem_addr=0x0010, mem_we=0; cpu_ack 5 cycles after req with cpu_rdata=0xBEEF; ldr_ack stays 0.
2. Core and loader both request in the same IDLE cycle, round-robin -> core granted first (owner=0), loader next (owner=1). Repeat with both held continuously -> grants alternate core, loader, core, and so on.
3. FIXED_PRI=1, both requesting continuously -> only the core is served; loader is granted only after cpu_req drops.
4. Loader write 0x1234 to 0x0100, then core read of 0x0100 -> mem_we=1 and mem_wdata=0x1234 on the loader ISSUE; core read returns 0x1234. During the core transaction ldr_rdata is unchanged and busy is high throughout.
5. Change cpu_addr from 0x0020 to 0x0030 in the cycle after grant -> mem_addr=0x0020. Hold cpu_req after ack -> a second transaction starts in the next IDLE.
6. Assert Reset during WAIT with MEM_LAT=4 -> busy, mem_en and acks are 0 in the same cycle and no ack is issued. After release, the core re-issues its request and it completes normally with MEM_LAT=1 timing checked separately (ack at N+4).
